multibyte_alu_sequencer: RTL and testbench

MULTIBYTE_ALU_SEQUENCER -- requirements
Module: multibyte_alu_sequencer

---
 rtl/multibyte_alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_multibyte_alu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_alu_sequencer.sv
// Runs a W-bit ADD/SUB/AND/OR through an external 8-bit ALU, one byte per cycle
// from the least significant byte up, then publishes the result and NZCV-style flags.
module multibyte_alu_sequencer #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES,
    localparam int IW = $clog2(NBYTES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         cin,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [1:0]   AluOp,
    output logic [7:0]   A,
    output logic [7:0]   B,
    output logic         CarryIn,
    input  logic [7:0]   AluOut,
    input  logic         AluCarry,
    output logic [W-1:0] result,
    output logic         Zero,
    output logic         Carry,
    output logic         Negative,
    output logic         Overflow,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic [1:0]    op_q, op_d;
    logic          cin_q, cin_d, chain_q, chain_d;
    logic          zero_q, zero_d, carry_flag_q, carry_flag_d;
    logic          neg_q, neg_d, ovf_q, ovf_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          is_sub, is_arith, b_eff_sign;
    logic [IW+2:0] bit_base;
    logic [7:0]    a_byte, b_byte;

    assign is_sub     = (op_q == OP_SUB);
    assign is_arith   = (op_q == OP_ADD) || is_sub;
    assign bit_base   = {idx_q, 3'b000};
    assign a_byte     = opa_q[bit_base +: 8];
    assign b_byte     = opb_q[bit_base +: 8];
    assign b_eff_sign = opb_q[W-1] ^ is_sub;

    // SUB is A + ~B + 1: the ALU always adds, the sequencer inverts B and forces carry-in.
    always_comb begin
        AluOp   = 2'b00;
        A       = 8'h00;
        B       = 8'h00;
        CarryIn = 1'b0;
        if (state_q == S_RUN) begin
            AluOp = is_arith ? OP_ADD : op_q;
            A     = a_byte;
            B     = is_sub ? ~b_byte : b_byte;
            if (idx_q == '0) CarryIn = is_sub | ((op_q == OP_ADD) & cin_q);
            else             CarryIn = is_arith & chain_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        cin_d        = cin_q;
        chain_d      = chain_q;
        result_d     = result_q;
        zero_d       = zero_q;
        carry_flag_d = carry_flag_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    opa_d   = opa;
                    opb_d   = opb;
                    op_d    = op;
                    cin_d   = cin;
                    chain_d = 1'b0;
                end
            end
            S_RUN: begin
                result_d[bit_base +: 8] = AluOut;
                chain_d = AluCarry;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d      = S_DONE;
                    idx_d        = '0;
                    done_d       = 1'b1;
                    zero_d       = (result_d == '0);
                    neg_d        = result_d[W-1];
                    carry_flag_d = is_arith & AluCarry;
                    ovf_d        = is_arith & (opa_q[W-1] == b_eff_sign) &
                                   (result_d[W-1] != opa_q[W-1]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= 2'b00;
            cin_q        <= 1'b0;
            chain_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            cin_q        <= cin_d;
            chain_q      <= chain_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            carry_flag_q <= carry_flag_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign result    = result_q;
    assign Zero      = zero_q;
    assign Carry     = carry_flag_q;
    assign Negative  = neg_q;
    assign Overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multibyte_alu_sequencer.sv
// Bench for multibyte_alu_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against a whole-word arithmetic reference model.
module tb_multibyte_alu_sequencer;

    localparam int NB = 4;
    localparam int W  = 32;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic clk = 1'b0;
    logic rst, start, cin;
    logic [1:0] op;
    logic [W-1:0] opa, opb;
    logic [1:0] AluOp;
    logic [7:0] A, B, AluOut;
    logic CarryIn, AluCarry;
    logic [W-1:0] result;
    logic Zero, Carry, Negative, Overflow, busy, done;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    int done_at, busy_cnt, done_cnt;
    logic [W-1:0] last_result;

    always #5 clk = ~clk;

    // 8-bit ALU: 00 add with carry, 01 and, 10 or.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'h000;
        case (AluOp)
            2'b00:   alu_sum = {1'b0, A} + {1'b0, B} + 9'(CarryIn);
            2'b01:   alu_sum = {1'b0, A & B};
            2'b10:   alu_sum = {1'b0, A | B};
            default: alu_sum = 9'h000;
        endcase
    end
    assign AluOut   = alu_sum[7:0];
    assign AluCarry = alu_sum[8];

    multibyte_alu_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
        .opa(opa), .opb(opb),
        .AluOp(AluOp), .A(A), .B(B), .CarryIn(CarryIn),
        .AluOut(AluOut), .AluCarry(AluCarry),
        .result(result), .Zero(Zero), .Carry(Carry), .Negative(Negative),
        .Overflow(Overflow), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: {result, Z, C, N, V} from whole-word arithmetic.
    function automatic logic [35:0] ref_calc(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic c);
        logic [32:0] u;
        logic [W-1:0] r;
        logic cf, vf;
        longint s;
        r = '0; cf = 1'b0; vf = 1'b0; u = '0; s = 0;
        case (o)
            OP_ADD: begin
                u  = {1'b0, a} + {1'b0, b} + 33'(c);
                r  = u[31:0];
                cf = u[32];
                s  = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
                vf = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                r  = a - b;
                cf = (a >= b);
                s  = longint'($signed(a)) - longint'($signed(b));
                vf = (s > SMAX) || (s < SMIN);
            end
            OP_AND: r = a & b;
            default: r = a | b;
        endcase
        return {r, (r == '0), cf, r[W-1], vf};
    endfunction

    // Carry entering byte i = carry out of the low 8*i bits of the effective sum.
    function automatic logic carry_into(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c, input int i);
        logic [63:0] m, sum, bb;
        logic c0;
        if (o == OP_AND || o == OP_OR) return 1'b0;
        bb = (o == OP_SUB) ? {32'h0, ~b} : {32'h0, b};
        c0 = (o == OP_SUB) ? 1'b1 : c;
        if (i == 0) return c0;
        m   = (64'd1 << (8 * i)) - 64'd1;
        sum = ({32'h0, a} & m) + (bb & m) + 64'(c0);
        return sum[8 * i];
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the idle
    // cycle right after DONE, so a following call starts back-to-back.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit spurious, input logic [35:0] exp);
        logic [35:0] got;
        logic [W-1:0] partial;
        logic [7:0] eb;
        logic [1:0] eop;
        got = '0; done_at = 0; busy_cnt = 0; done_cnt = 0;
        eop = (o == OP_AND) ? 2'b01 : (o == OP_OR) ? 2'b10 : 2'b00;
        op = o; opa = a; opb = b; cin = c; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = spurious && (k <= 3);
            if (spurious && k <= 3) begin
                op = 2'($urandom); opa = $urandom; opb = $urandom; cin = 1'($urandom);
            end
            if (busy) begin
                busy_cnt++;
                if (k <= NB) begin
                    eb = (o == OP_SUB) ? ~b[8*(k-1) +: 8] : b[8*(k-1) +: 8];
                    check("alu_drive", {AluOp, A, B, CarryIn},
                          {eop, a[8*(k-1) +: 8], eb, carry_into(o, a, b, c, k - 1)});
                    for (int j = 0; j < NB; j++)
                        partial[8*j +: 8] = (j < k - 1) ? exp[4 + 8*j +: 8] : last_result[8*j +: 8];
                    check("partial_result", result, partial);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = k;
                    got = {result, Zero, Carry, Negative, Overflow};
                    check("done_alu_idle", {AluOp, A, B, CarryIn}, 19'h0);
                end
            end
            if (done_at != 0 && k == done_at + 1) begin
                check("hold_result", {result, Zero, Carry, Negative, Overflow}, got);
                break;
            end
        end
        start = 1'b0;
        last_result = exp[35:4];
        check("done_latency", 64'(done_at), 64'(NB + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(NB));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("result_flags", got, exp);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic         z, cf, n, v;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        logic rc;
        bit sp;

        rst = 1'b0; start = 1'b0; op = 2'b00; cin = 1'b0; opa = '0; opb = '0;
        last_result = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_flags", {Zero, Carry, Negative, Overflow, busy, done}, 6'h0);
        check("reset_alu_drive", {AluOp, A, B, CarryIn}, 19'h0);
        rst = 1'b1;
        @(negedge clk);

        //        op      a             b             c     result        z     c     n     v
        vecs[0] = '{OP_ADD, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{OP_SUB, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{OP_SUB, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{OP_OR,  32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{OP_ADD, 32'h000000FE, 32'h00000001, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, (i == 3),
                   {vecs[i].r, vecs[i].z, vecs[i].cf, vecs[i].n, vecs[i].v});

        // Reset during the second RUN cycle aborts without a done pulse.
        op = OP_ADD; opa = 32'h11111111; opb = 32'h22222222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy_done", {busy, done}, 2'b00);
        check("abort_result", result, 32'h0);
        check("abort_flags", {Zero, Carry, Negative, Overflow}, 4'h0);
        rst = 1'b1;
        done_cnt = 0;
        repeat (7) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_quiet", 64'(done_cnt), 64'd0);
        last_result = '0;

        // Reset wins over start on the same edge.
        rst = 1'b0; start = 1'b1; op = OP_ADD; opa = 32'h1; opb = 32'h1;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        check("rst_priority_busy", {busy, done}, 2'b00);
        @(negedge clk);
        check("rst_priority_idle", {busy, done, AluOp, A, B, CarryIn}, 21'h0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 - 32'($urandom_range(0, 1)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF * 32'($urandom_range(0, 1)) : $urandom;
            rc = 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 3) == 0);
            run_op(ro, ra, rb, rc, sp, ref_calc(ro, ra, rb, rc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
